// File: rtl/tl_source_remapper.sv
// rtl/tl_source_remapper.sv - TileLink-UL/UH source-ID remapper with per-request tracking table.
// Optional unknown-source check on D: TL_SOURCE_REMAP_CHECK_EN.
module tl_source_remapper #(
    parameter int DataWidth         = 64,
    parameter int AddrWidth         = 56,
    parameter int SinkWidth         = 1,
    parameter int HostSourceWidth   = 4,
    parameter int DeviceSourceWidth = 2,
    parameter int NumEntries        = 2 ** DeviceSourceWidth,
    parameter int MaxSize           = 6,
    localparam int SizeWidth        = $clog2(MaxSize + 1),
    localparam int MaskWidth        = DataWidth / 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    // host side: A in, B out, C in, D out, E in
    input  logic                         host_a_valid,
    output logic                         host_a_ready,
    input  logic [2:0]                   host_a_opcode,
    input  logic [2:0]                   host_a_param,
    input  logic [SizeWidth-1:0]         host_a_size,
    input  logic [HostSourceWidth-1:0]   host_a_source,
    input  logic [AddrWidth-1:0]         host_a_address,
    input  logic [MaskWidth-1:0]         host_a_mask,
    input  logic [DataWidth-1:0]         host_a_data,
    input  logic                         host_a_corrupt,
    output logic                         host_b_valid,
    input  logic                         host_b_ready,
    output logic [2:0]                   host_b_opcode,
    output logic [1:0]                   host_b_param,
    output logic [SizeWidth-1:0]         host_b_size,
    output logic [HostSourceWidth-1:0]   host_b_source,
    output logic [AddrWidth-1:0]         host_b_address,
    output logic [MaskWidth-1:0]         host_b_mask,
    output logic [DataWidth-1:0]         host_b_data,
    output logic                         host_b_corrupt,
    input  logic                         host_c_valid,
    output logic                         host_c_ready,
    input  logic [2:0]                   host_c_opcode,
    input  logic [2:0]                   host_c_param,
    input  logic [SizeWidth-1:0]         host_c_size,
    input  logic [HostSourceWidth-1:0]   host_c_source,
    input  logic [AddrWidth-1:0]         host_c_address,
    input  logic [DataWidth-1:0]         host_c_data,
    input  logic                         host_c_corrupt,
    output logic                         host_d_valid,
    input  logic                         host_d_ready,
    output logic [2:0]                   host_d_opcode,
    output logic [1:0]                   host_d_param,
    output logic [SizeWidth-1:0]         host_d_size,
    output logic [HostSourceWidth-1:0]   host_d_source,
    output logic [SinkWidth-1:0]         host_d_sink,
    output logic                         host_d_denied,
    output logic [DataWidth-1:0]         host_d_data,
    output logic                         host_d_corrupt,
    input  logic                         host_e_valid,
    output logic                         host_e_ready,
    input  logic [SinkWidth-1:0]         host_e_sink,
    // device side: A out, B in, C out, D in, E out
    output logic                         device_a_valid,
    input  logic                         device_a_ready,
    output logic [2:0]                   device_a_opcode,
    output logic [2:0]                   device_a_param,
    output logic [SizeWidth-1:0]         device_a_size,
    output logic [DeviceSourceWidth-1:0] device_a_source,
    output logic [AddrWidth-1:0]         device_a_address,
    output logic [MaskWidth-1:0]         device_a_mask,
    output logic [DataWidth-1:0]         device_a_data,
    output logic                         device_a_corrupt,
    input  logic                         device_b_valid,
    output logic                         device_b_ready,
    input  logic [2:0]                   device_b_opcode,
    input  logic [1:0]                   device_b_param,
    input  logic [SizeWidth-1:0]         device_b_size,
    input  logic [DeviceSourceWidth-1:0] device_b_source,
    input  logic [AddrWidth-1:0]         device_b_address,
    input  logic [MaskWidth-1:0]         device_b_mask,
    input  logic [DataWidth-1:0]         device_b_data,
    input  logic                         device_b_corrupt,
    output logic                         device_c_valid,
    input  logic                         device_c_ready,
    output logic [2:0]                   device_c_opcode,
    output logic [2:0]                   device_c_param,
    output logic [SizeWidth-1:0]         device_c_size,
    output logic [DeviceSourceWidth-1:0] device_c_source,
    output logic [AddrWidth-1:0]         device_c_address,
    output logic [DataWidth-1:0]         device_c_data,
    output logic                         device_c_corrupt,
    input  logic                         device_d_valid,
    output logic                         device_d_ready,
    input  logic [2:0]                   device_d_opcode,
    input  logic [1:0]                   device_d_param,
    input  logic [SizeWidth-1:0]         device_d_size,
    input  logic [DeviceSourceWidth-1:0] device_d_source,
    input  logic [SinkWidth-1:0]         device_d_sink,
    input  logic                         device_d_denied,
    input  logic [DataWidth-1:0]         device_d_data,
    input  logic                         device_d_corrupt,
    output logic                         device_e_valid,
    input  logic                         device_e_ready,
    output logic [SinkWidth-1:0]         device_e_sink,
    output logic                         err_o
);

    localparam int BeatLog2 = $clog2(DataWidth / 8);
    localparam int CntRaw   = MaxSize - BeatLog2;
    localparam int CntWidth = (CntRaw > 1) ? CntRaw : 1;

    // Beats in a message minus one; doubles as the counter preload for a burst.
    function automatic logic [CntWidth-1:0] beats_m1(input logic has_data,
                                                     input logic [SizeWidth-1:0] size);
        logic [CntWidth-1:0] r;
        r = '0;
        if (has_data && (int'(size) > BeatLog2)) begin
            r = CntWidth'((1 << (int'(size) - BeatLog2)) - 1);
        end
        return r;
    endfunction

    logic [NumEntries-1:0]        ent_valid;
    logic [HostSourceWidth-1:0]   ent_src [NumEntries];
    logic [CntWidth-1:0]          a_cnt;
    logic [CntWidth-1:0]          d_cnt;
    logic [DeviceSourceWidth-1:0] burst_idx;

    logic                         any_free;
    logic [DeviceSourceWidth-1:0] free_idx;
    logic                         a_first;
    logic                         a_gate;
    logic                         a_fire;
    logic [CntWidth-1:0]          a_beats_m1;
    logic                         d_entry_valid;
    logic [HostSourceWidth-1:0]   d_host_src;
    logic                         d_first;
    logic                         d_last;
    logic                         d_fire;
    logic [CntWidth-1:0]          d_beats_m1;

    // Lowest free index wins, so scan downwards and let the last hit stick.
    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        for (int i = NumEntries - 1; i >= 0; i--) begin
            if (!ent_valid[i]) begin
                any_free = 1'b1;
                free_idx = DeviceSourceWidth'(i);
            end
        end
    end

    // Sources at or beyond NumEntries match no entry and read as invalid.
    always_comb begin
        d_entry_valid = 1'b0;
        d_host_src    = '0;
        for (int i = 0; i < NumEntries; i++) begin
            if (device_d_source == DeviceSourceWidth'(i)) begin
                d_entry_valid = ent_valid[i];
                d_host_src    = ent_src[i];
            end
        end
    end

    assign a_first    = (a_cnt == '0);
    assign a_gate     = a_first ? any_free : 1'b1;
    assign a_beats_m1 = beats_m1(~host_a_opcode[2], host_a_size);

    assign device_a_valid   = ~rst_i & host_a_valid & a_gate;
    assign host_a_ready     = ~rst_i & device_a_ready & a_gate;
    assign a_fire           = host_a_valid & host_a_ready;
    assign device_a_opcode  = host_a_opcode;
    assign device_a_param   = host_a_param;
    assign device_a_size    = host_a_size;
    assign device_a_source  = a_first ? free_idx : burst_idx;
    assign device_a_address = host_a_address;
    assign device_a_mask    = host_a_mask;
    assign device_a_data    = host_a_data;
    assign device_a_corrupt = host_a_corrupt;

    assign d_first    = (d_cnt == '0);
    assign d_beats_m1 = beats_m1(device_d_opcode == 3'd1, device_d_size);
    assign d_last     = d_first ? (d_beats_m1 == '0) : (d_cnt == CntWidth'(1));

`ifdef TL_SOURCE_REMAP_CHECK_EN
    logic err_q;

    // Beats for unallocated slots are swallowed so the host never sees them.
    assign host_d_valid   = ~rst_i & device_d_valid & d_entry_valid;
    assign device_d_ready = ~rst_i & (d_entry_valid ? host_d_ready : 1'b1);
    assign err_o          = err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (d_fire && !d_entry_valid) begin
            err_q <= 1'b1;
        end
    end
`else
    assign host_d_valid   = ~rst_i & device_d_valid;
    assign device_d_ready = ~rst_i & host_d_ready;
    assign err_o          = 1'b0;
`endif

    assign d_fire         = device_d_valid & device_d_ready;
    assign host_d_opcode  = device_d_opcode;
    assign host_d_param   = device_d_param;
    assign host_d_size    = device_d_size;
    assign host_d_source  = d_host_src;
    assign host_d_sink    = device_d_sink;
    assign host_d_denied  = device_d_denied;
    assign host_d_data    = device_d_data;
    assign host_d_corrupt = device_d_corrupt;

    assign host_b_valid   = 1'b0;
    assign host_b_opcode  = '0;
    assign host_b_param   = '0;
    assign host_b_size    = '0;
    assign host_b_source  = '0;
    assign host_b_address = '0;
    assign host_b_mask    = '0;
    assign host_b_data    = '0;
    assign host_b_corrupt = 1'b0;
    assign host_c_ready   = 1'b1;
    assign host_e_ready   = 1'b1;

    assign device_b_ready   = 1'b1;
    assign device_c_valid   = 1'b0;
    assign device_c_opcode  = '0;
    assign device_c_param   = '0;
    assign device_c_size    = '0;
    assign device_c_source  = '0;
    assign device_c_address = '0;
    assign device_c_data    = '0;
    assign device_c_corrupt = 1'b0;
    assign device_e_valid   = 1'b0;
    assign device_e_sink    = '0;

    logic unused_inputs;
    assign unused_inputs = ^{host_b_ready, host_c_valid, host_c_opcode, host_c_param, host_c_size,
                             host_c_source, host_c_address, host_c_data, host_c_corrupt,
                             host_e_valid, host_e_sink, device_b_valid, device_b_opcode,
                             device_b_param, device_b_size, device_b_source, device_b_address,
                             device_b_mask, device_b_data, device_b_corrupt, device_c_ready,
                             device_e_ready, d_entry_valid};

    // A free and an allocation never hit the same slot: only invalid slots are allocated.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ent_valid <= '0;
            for (int i = 0; i < NumEntries; i++) begin
                ent_src[i] <= '0;
            end
            a_cnt     <= '0;
            d_cnt     <= '0;
            burst_idx <= '0;
        end else begin
            if (d_fire) begin
                d_cnt <= d_first ? d_beats_m1 : (d_cnt - CntWidth'(1));
                if (d_last) begin
                    for (int i = 0; i < NumEntries; i++) begin
                        if (device_d_source == DeviceSourceWidth'(i)) begin
                            ent_valid[i] <= 1'b0;
                        end
                    end
                end
            end
            if (a_fire) begin
                if (a_first) begin
                    a_cnt     <= a_beats_m1;
                    burst_idx <= free_idx;
                    for (int i = 0; i < NumEntries; i++) begin
                        if (free_idx == DeviceSourceWidth'(i)) begin
                            ent_valid[i] <= 1'b1;
                            ent_src[i]   <= host_a_source;
                        end
                    end
                end else begin
                    a_cnt <= a_cnt - CntWidth'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_tl_source_remapper.sv
// tb/tb_tl_source_remapper.sv - directed-vector bench for tl_source_remapper.
module tb_tl_source_remapper;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        host_a_valid, host_a_ready, host_a_corrupt;
    logic [2:0]  host_a_opcode, host_a_param, host_a_size;
    logic [3:0]  host_a_source;
    logic [55:0] host_a_address;
    logic [7:0]  host_a_mask;
    logic [63:0] host_a_data;
    logic        host_b_valid, host_b_corrupt;
    logic [2:0]  host_b_opcode, host_b_size;
    logic [1:0]  host_b_param;
    logic [3:0]  host_b_source;
    logic [55:0] host_b_address;
    logic [7:0]  host_b_mask;
    logic [63:0] host_b_data;
    logic        host_c_ready;
    logic        host_d_valid, host_d_ready, host_d_denied, host_d_corrupt;
    logic [2:0]  host_d_opcode, host_d_size;
    logic [1:0]  host_d_param;
    logic [3:0]  host_d_source;
    logic [0:0]  host_d_sink;
    logic [63:0] host_d_data;
    logic        host_e_ready;
    logic        device_a_valid, device_a_ready, device_a_corrupt;
    logic [2:0]  device_a_opcode, device_a_param, device_a_size;
    logic [1:0]  device_a_source;
    logic [55:0] device_a_address;
    logic [7:0]  device_a_mask;
    logic [63:0] device_a_data;
    logic        device_b_ready;
    logic        device_c_valid, device_c_corrupt;
    logic [2:0]  device_c_opcode, device_c_param, device_c_size;
    logic [1:0]  device_c_source;
    logic [55:0] device_c_address;
    logic [63:0] device_c_data;
    logic        device_d_valid, device_d_ready;
    logic [2:0]  device_d_opcode, device_d_size;
    logic [1:0]  device_d_source;
    logic        device_e_valid;
    logic [0:0]  device_e_sink;
    logic        err;

    tl_source_remapper dut (
        .clk_i(clk), .rst_i(rst),
        .host_a_valid(host_a_valid), .host_a_ready(host_a_ready), .host_a_opcode(host_a_opcode),
        .host_a_param(host_a_param), .host_a_size(host_a_size), .host_a_source(host_a_source),
        .host_a_address(host_a_address), .host_a_mask(host_a_mask), .host_a_data(host_a_data),
        .host_a_corrupt(host_a_corrupt),
        .host_b_valid(host_b_valid), .host_b_ready(1'b1), .host_b_opcode(host_b_opcode),
        .host_b_param(host_b_param), .host_b_size(host_b_size), .host_b_source(host_b_source),
        .host_b_address(host_b_address), .host_b_mask(host_b_mask), .host_b_data(host_b_data),
        .host_b_corrupt(host_b_corrupt),
        .host_c_valid(1'b0), .host_c_ready(host_c_ready), .host_c_opcode(3'd0), .host_c_param(3'd0),
        .host_c_size(3'd0), .host_c_source(4'd0), .host_c_address(56'd0), .host_c_data(64'd0),
        .host_c_corrupt(1'b0),
        .host_d_valid(host_d_valid), .host_d_ready(host_d_ready), .host_d_opcode(host_d_opcode),
        .host_d_param(host_d_param), .host_d_size(host_d_size), .host_d_source(host_d_source),
        .host_d_sink(host_d_sink), .host_d_denied(host_d_denied), .host_d_data(host_d_data),
        .host_d_corrupt(host_d_corrupt),
        .host_e_valid(1'b0), .host_e_ready(host_e_ready), .host_e_sink(1'b0),
        .device_a_valid(device_a_valid), .device_a_ready(device_a_ready),
        .device_a_opcode(device_a_opcode), .device_a_param(device_a_param),
        .device_a_size(device_a_size), .device_a_source(device_a_source),
        .device_a_address(device_a_address), .device_a_mask(device_a_mask),
        .device_a_data(device_a_data), .device_a_corrupt(device_a_corrupt),
        .device_b_valid(1'b0), .device_b_ready(device_b_ready), .device_b_opcode(3'd0),
        .device_b_param(2'd0), .device_b_size(3'd0), .device_b_source(2'd0),
        .device_b_address(56'd0), .device_b_mask(8'd0), .device_b_data(64'd0),
        .device_b_corrupt(1'b0),
        .device_c_valid(device_c_valid), .device_c_ready(1'b1), .device_c_opcode(device_c_opcode),
        .device_c_param(device_c_param), .device_c_size(device_c_size),
        .device_c_source(device_c_source), .device_c_address(device_c_address),
        .device_c_data(device_c_data), .device_c_corrupt(device_c_corrupt),
        .device_d_valid(device_d_valid), .device_d_ready(device_d_ready),
        .device_d_opcode(device_d_opcode), .device_d_param(2'd0), .device_d_size(device_d_size),
        .device_d_source(device_d_source), .device_d_sink(1'b0), .device_d_denied(1'b0),
        .device_d_data(64'h0123_4567_89ab_cdef), .device_d_corrupt(1'b0),
        .device_e_valid(device_e_valid), .device_e_ready(1'b1), .device_e_sink(device_e_sink),
        .err_o(err)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic a_req(input logic [2:0] op, input logic [2:0] size, input logic [3:0] src);
        host_a_valid  = 1'b1;
        host_a_opcode = op;
        host_a_size   = size;
        host_a_source = src;
    endtask

    task automatic a_idle();
        host_a_valid = 1'b0;
    endtask

    task automatic d_rsp(input logic [2:0] op, input logic [2:0] size, input logic [1:0] src);
        device_d_valid  = 1'b1;
        device_d_opcode = op;
        device_d_size   = size;
        device_d_source = src;
    endtask

    task automatic d_idle();
        device_d_valid = 1'b0;
    endtask

    // Returns each slot with a single-beat AccessAck and checks the restored host source.
    task automatic drain(input int n, input logic [3:0] s0, input logic [3:0] s1,
                         input logic [3:0] s2, input logic [3:0] s3);
        logic [3:0] exp_src [4];
        exp_src[0] = s0; exp_src[1] = s1; exp_src[2] = s2; exp_src[3] = s3;
        for (int k = 0; k < n; k++) begin
            d_rsp(3'd0, 3'd3, 2'(k));
            #1 check($sformatf("drain_src%0d", k), 64'(host_d_source), 64'(exp_src[k]));
            tick();
        end
        d_idle();
        #1 check("drain_empty", 64'(device_a_source), 64'd0);
    endtask

    logic [3:0] fill_src [4];
    int hs;

    initial begin
        host_a_valid = 1'b1; host_a_opcode = 3'd4; host_a_param = 3'd0; host_a_size = 3'd3;
        host_a_source = 4'd0; host_a_address = 56'h1000; host_a_mask = 8'hff;
        host_a_data = 64'd0; host_a_corrupt = 1'b0;
        device_a_ready = 1'b1; host_d_ready = 1'b1;
        device_d_valid = 1'b1; device_d_opcode = 3'd1; device_d_size = 3'd3; device_d_source = 2'd0;

        // reset gating
        #1;
        check("rst_dev_a_valid", 64'(device_a_valid), 64'd0);
        check("rst_host_a_ready", 64'(host_a_ready), 64'd0);
        check("rst_host_d_valid", 64'(host_d_valid), 64'd0);
        check("rst_dev_d_ready", 64'(device_d_ready), 64'd0);
        tick(); tick();
        a_idle(); d_idle();
        rst = 1'b0;
        #1;
        check("rst_err", 64'(err), 64'd0);
        check("rst_free_idx", 64'(device_a_source), 64'd0);
        check("unused_b_valid", 64'(host_b_valid), 64'd0);
        check("unused_c_ready", 64'(host_c_ready), 64'd1);

        // single Get
        tick();
        a_req(3'd4, 3'd3, 4'hB);
        #1;
        check("get_dev_valid", 64'(device_a_valid), 64'd1);
        check("get_dev_src", 64'(device_a_source), 64'd0);
        check("get_ready", 64'(host_a_ready), 64'd1);
        tick();
        a_idle();
        d_rsp(3'd1, 3'd3, 2'd0);
        #1;
        check("get_d_valid", 64'(host_d_valid), 64'd1);
        check("get_d_src", 64'(host_d_source), 64'hB);
        check("get_entry0_busy", 64'(device_a_source), 64'd1);
        tick();
        d_idle();
        #1 check("get_entry0_freed", 64'(device_a_source), 64'd0);

        // fill the table, fifth request stalls until a slot is returned
        fill_src[0] = 4'h1; fill_src[1] = 4'h5; fill_src[2] = 4'h9; fill_src[3] = 4'hF;
        for (int k = 0; k < 4; k++) begin
            a_req(3'd4, 3'd3, fill_src[k]);
            #1;
            check($sformatf("fill_src%0d", k), 64'(device_a_source), 64'(k));
            check($sformatf("fill_ready%0d", k), 64'(host_a_ready), 64'd1);
            tick();
        end
        a_req(3'd4, 3'd3, 4'h7);
        #1;
        check("full_ready", 64'(host_a_ready), 64'd0);
        check("full_dev_valid", 64'(device_a_valid), 64'd0);
        d_rsp(3'd1, 3'd3, 2'd2);
        #1;
        check("full_d_src", 64'(host_d_source), 64'h9);
        check("full_no_bypass", 64'(host_a_ready), 64'd0);
        tick();
        d_idle();
        #1;
        check("refill_ready", 64'(host_a_ready), 64'd1);
        check("refill_src", 64'(device_a_source), 64'd2);
        tick();
        a_idle();
        drain(4, 4'h1, 4'h5, 4'h7, 4'hF);

        // 8-beat PutFull takes the last slot; later beats ignore occupancy
        for (int k = 0; k < 3; k++) begin
            a_req(3'd4, 3'd3, 4'(k + 2));
            tick();
        end
        a_req(3'd0, 3'd6, 4'hA);
        for (int b = 0; b < 8; b++) begin
            #1;
            check($sformatf("burst_src%0d", b), 64'(device_a_source), 64'd3);
            check($sformatf("burst_ready%0d", b), 64'(host_a_ready), 64'd1);
            tick();
        end
        a_req(3'd4, 3'd3, 4'h6);
        #1 check("burst_after_full", 64'(host_a_ready), 64'd0);
        d_rsp(3'd0, 3'd6, 2'd3);
        #1 check("burst_ack_src", 64'(host_d_source), 64'hA);
        tick();
        d_idle();
        #1;
        check("burst_freed_ready", 64'(host_a_ready), 64'd1);
        check("burst_freed_src", 64'(device_a_source), 64'd3);
        a_idle();
        drain(3, 4'h2, 4'h3, 4'h4, 4'h0);

        // 4-beat AccessAckData with host_d_ready toggling
        a_req(3'd4, 3'd5, 4'hC);
        tick();
        a_idle();
        d_rsp(3'd1, 3'd5, 2'd0);
        hs = 0;
        for (int c = 0; c < 7; c++) begin
            host_d_ready = (c % 2 == 0);
            #1;
            check($sformatf("mb_src%0d", c), 64'(host_d_source), 64'hC);
            check($sformatf("mb_busy%0d", c), 64'(device_a_source), 64'd1);
            if (host_d_ready) hs++;
            tick();
        end
        d_idle();
        host_d_ready = 1'b1;
        #1;
        check("mb_handshakes", 64'(hs), 64'd4);
        check("mb_freed", 64'(device_a_source), 64'd0);

        // free of slot 1 and allocation of slot 2 in the same cycle
        a_req(3'd4, 3'd3, 4'h1); tick();
        a_req(3'd4, 3'd3, 4'h2); tick();
        a_req(3'd4, 3'd3, 4'h3);
        d_rsp(3'd0, 3'd3, 2'd1);
        #1;
        check("sim_alloc_src", 64'(device_a_source), 64'd2);
        check("sim_free_src", 64'(host_d_source), 64'h2);
        tick();
        a_idle(); d_idle();
        #1 check("sim_reuse_idx", 64'(device_a_source), 64'd1);
        a_req(3'd4, 3'd3, 4'h5);
        #1 check("sim_reuse_ready", 64'(host_a_ready), 64'd1);
        tick();
        a_idle();
        drain(3, 4'h1, 4'h5, 4'h3, 4'h0);

`ifdef TL_SOURCE_REMAP_CHECK_EN
        d_rsp(3'd1, 3'd3, 2'd3);
        #1;
        check("chk_no_fwd", 64'(host_d_valid), 64'd0);
        check("chk_accept", 64'(device_d_ready), 64'd1);
        tick();
        d_idle();
        #1 check("chk_err_set", 64'(err), 64'd1);
        tick();
        #1 check("chk_err_sticky", 64'(err), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1 check("chk_err_clr", 64'(err), 64'd0);
`else
        check("err_tied", 64'(err), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
